// File: rtl/kwan_control_unit.sv
// Microcode sequencer for the kwanCPU: a T-state counter plus a halt flag, with a
// combinational decode of (tstep, opcode, flags) into the datapath control strobes.
module kwan_control_unit #(
  parameter int N     = 8,
  parameter int STEPS = 5
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [N-1:0] ir,
  input  logic         cf,
  input  logic         zf,
  input  logic         prog,
  output logic         co,
  output logic         mi,
  output logic         ro,
  output logic         ri,
  output logic         ii,
  output logic         io,
  output logic         ce,
  output logic         j,
  output logic         ai,
  output logic         ao,
  output logic         bi,
  output logic         eo,
  output logic         su,
  output logic         fi,
  output logic         oi,
  output logic         hlt,
  output logic         halted,
  output logic [2:0]   tstep
);

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

  opcode_t opcode;
  logic    unused_operand;
  logic    ctrl_enable;

  assign opcode         = opcode_t'(ir[N-1:N-4]);
  // The operand reaches the bus through the IR itself; only io is generated here.
  assign unused_operand = ^ir[N-5:0];
  assign ctrl_enable    = !(clr || prog || halted);

  // Step counter and halt flag. Halting freezes tstep at 2 until clr.
  always_ff @(posedge clk) begin
    if (clr) begin
      tstep  <= 3'd0;
      halted <= 1'b0;
    end else if (prog) begin
      tstep  <= 3'd0;
    end else if (!halted) begin
      if (tstep == 3'd2 && opcode == OP_HLT) begin
        halted <= 1'b1;
      end else if (tstep == LAST_STEP) begin
        tstep <= 3'd0;
      end else begin
        tstep <= tstep + 3'd1;
      end
    end
  end

  always_comb begin
    co  = 1'b0;
    mi  = 1'b0;
    ro  = 1'b0;
    ri  = 1'b0;
    ii  = 1'b0;
    io  = 1'b0;
    ce  = 1'b0;
    j   = 1'b0;
    ai  = 1'b0;
    ao  = 1'b0;
    bi  = 1'b0;
    eo  = 1'b0;
    su  = 1'b0;
    fi  = 1'b0;
    oi  = 1'b0;
    hlt = 1'b0;
    if (ctrl_enable) begin
      case (tstep)
        3'd0: begin
          co = 1'b1;
          mi = 1'b1;
        end
        3'd1: begin
          ro = 1'b1;
          ii = 1'b1;
          ce = 1'b1;
        end
        3'd2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              io = 1'b1;
              mi = 1'b1;
            end
            OP_LDI: begin
              io = 1'b1;
              ai = 1'b1;
            end
            OP_JMP: begin
              io = 1'b1;
              j  = 1'b1;
            end
            // Conditional jumps look at the flags in this step only.
            OP_JC: begin
              io = cf;
              j  = cf;
            end
            OP_JZ: begin
              io = zf;
              j  = zf;
            end
            OP_OUT: begin
              ao = 1'b1;
              oi = 1'b1;
            end
            OP_HLT: hlt = 1'b1;
            default: ;
          endcase
        end
        3'd3: begin
          case (opcode)
            OP_LDA: begin
              ro = 1'b1;
              ai = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ro = 1'b1;
              bi = 1'b1;
            end
            OP_STA: begin
              ao = 1'b1;
              ri = 1'b1;
            end
            default: ;
          endcase
        end
        3'd4: begin
          case (opcode)
            OP_ADD: begin
              eo = 1'b1;
              ai = 1'b1;
              fi = 1'b1;
            end
            OP_SUB: begin
              eo = 1'b1;
              ai = 1'b1;
              su = 1'b1;
              fi = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kwan_control_unit.sv
// Bench for kwan_control_unit: a table-driven instruction model checked every cycle,
// plus directed instruction sequences with literal per-step control words.
module tb_kwan_control_unit;

  localparam int N     = 8;
  localparam int STEPS = 5;

  localparam logic [15:0] CO  = 16'h8000;
  localparam logic [15:0] MI  = 16'h4000;
  localparam logic [15:0] RO  = 16'h2000;
  localparam logic [15:0] RI  = 16'h1000;
  localparam logic [15:0] II  = 16'h0800;
  localparam logic [15:0] IO  = 16'h0400;
  localparam logic [15:0] CE  = 16'h0200;
  localparam logic [15:0] J   = 16'h0100;
  localparam logic [15:0] AI  = 16'h0080;
  localparam logic [15:0] AO  = 16'h0040;
  localparam logic [15:0] BI  = 16'h0020;
  localparam logic [15:0] EO  = 16'h0010;
  localparam logic [15:0] SU  = 16'h0008;
  localparam logic [15:0] FI  = 16'h0004;
  localparam logic [15:0] OI  = 16'h0002;
  localparam logic [15:0] HLT = 16'h0001;
  localparam logic [15:0] Z   = 16'h0000;

  logic         clk = 1'b0;
  logic         clr;
  logic [N-1:0] ir;
  logic         cf;
  logic         zf;
  logic         prog;
  logic         co, mi, ro, ri, ii, io, ce, j;
  logic         ai, ao, bi, eo, su, fi, oi, hlt, halted;
  logic [2:0]   tstep;
  logic [15:0]  dut_word;

  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;

  // Model state and per-opcode microcode table (steps 0/1 handled as fetch).
  int          m_step;
  logic        m_halted;
  logic [15:0] micro [16][8];
  logic [15:0] exp_q [$];

  kwan_control_unit #(.N(N), .STEPS(STEPS)) dut (
    .clk(clk), .clr(clr), .ir(ir), .cf(cf), .zf(zf), .prog(prog),
    .co(co), .mi(mi), .ro(ro), .ri(ri), .ii(ii), .io(io), .ce(ce), .j(j),
    .ai(ai), .ao(ao), .bi(bi), .eo(eo), .su(su), .fi(fi), .oi(oi),
    .hlt(hlt), .halted(halted), .tstep(tstep)
  );

  assign dut_word = {co, mi, ro, ri, ii, io, ce, j, ai, ao, bi, eo, su, fi, oi, hlt};

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] model_word(input logic [3:0] op, input int step,
                                             input logic c, input logic z,
                                             input logic hl, input logic rst, input logic pg);
    logic [15:0] w;
    if (rst || pg || hl) return Z;
    if (step == 0) return CO | MI;
    if (step == 1) return RO | II | CE;
    w = micro[op][step];
    if (step == 2 && op == 4'h7 && !c) w = Z;
    if (step == 2 && op == 4'h8 && !z) w = Z;
    return w;
  endfunction

  always @(posedge clk) begin
    if (clr) begin
      m_step   = 0;
      m_halted = 1'b0;
    end else if (prog) begin
      m_step = 0;
    end else if (!m_halted) begin
      if (m_step == 2 && ir[7:4] == 4'hF) m_halted = 1'b1;
      else m_step = (m_step + 1) % STEPS;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_word", dut_word, model_word(ir[7:4], m_step, cf, zf, m_halted, clr, prog));
      chk("model_tstep", {13'b0, tstep}, 16'(m_step));
      chk("model_halted", {15'b0, halted}, {15'b0, m_halted});
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge, checks at the falling edge
  task automatic edge_t();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Starting from an observed T0, runs one full instruction and checks each step.
  task automatic run_instr(input logic [7:0] op_ir, input logic c, input logic z,
                           input logic [15:0] ew [5]);
    chk("t0_word", dut_word, ew[0]);
    for (int s = 1; s <= STEPS; s++) exp_q.push_back(ew[s % STEPS]);
    for (int s = 1; s <= STEPS; s++) begin
      edge_t();
      if (s == 1) ir = op_ir;
      cf = (s == 2) ? c : 1'($urandom_range(0, 1));
      zf = (s == 2) ? z : 1'($urandom_range(0, 1));
      sample();
      chk("step_tstep", {13'b0, tstep}, 16'(s % STEPS));
      chk("step_word", dut_word, exp_q.pop_front());
    end
  endtask

  task automatic do_halt(input logic with_prog);
    edge_t();
    ir = 8'hF0;
    sample();
    chk("halt_t1", dut_word, RO | II | CE);
    edge_t();
    sample();
    chk("halt_hlt", {15'b0, hlt}, 16'h0001);
    chk("halt_t2_word", dut_word, HLT);
    chk("halt_not_yet", {15'b0, halted}, 16'h0000);
    for (int k = 0; k < 10; k++) begin
      edge_t();
      sample();
      chk("halted_flag", {15'b0, halted}, 16'h0001);
      chk("halted_tstep", {13'b0, tstep}, 16'h0002);
      chk("halted_word", dut_word, Z);
    end
    edge_t();
    clr  = 1'b1;
    prog = with_prog;
    sample();
    chk("halt_clr_word", dut_word, Z);
    edge_t();
    clr  = 1'b0;
    prog = 1'b0;
    sample();
    chk("recover_halted", {15'b0, halted}, 16'h0000);
    chk("recover_tstep", {13'b0, tstep}, 16'h0000);
    chk("recover_word", dut_word, CO | MI);
  endtask

  initial begin
    clr  = 1'b1;
    prog = 1'b0;
    ir   = 8'h00;
    cf   = 1'b0;
    zf   = 1'b0;
    for (int op = 0; op < 16; op++)
      for (int s = 0; s < 8; s++) micro[op][s] = Z;
    micro[1][2]  = IO | MI;  micro[1][3] = RO | AI;
    micro[2][2]  = IO | MI;  micro[2][3] = RO | BI;  micro[2][4] = EO | AI | FI;
    micro[3][2]  = IO | MI;  micro[3][3] = RO | BI;  micro[3][4] = EO | AI | SU | FI;
    micro[4][2]  = IO | MI;  micro[4][3] = AO | RI;
    micro[5][2]  = IO | AI;
    micro[6][2]  = IO | J;
    micro[7][2]  = IO | J;
    micro[8][2]  = IO | J;
    micro[14][2] = AO | OI;
    micro[15][2] = HLT;

    // Reset held for two edges, then fetch of a NOP.
    edge_t();
    check_en = 1'b1;
    sample();
    chk("reset_tstep", {13'b0, tstep}, 16'h0000);
    chk("reset_halted", {15'b0, halted}, 16'h0000);
    chk("reset_word", dut_word, Z);
    edge_t();
    clr = 1'b0;
    sample();
    chk("first_fetch", dut_word, CO | MI);

    run_instr(8'h00, 1'b0, 1'b0, '{CO | MI, RO | II | CE, Z, Z, Z});
    run_instr(8'h3F, 1'b0, 1'b0, '{CO | MI, RO | II | CE, IO | MI, RO | BI, EO | AI | SU | FI});
    run_instr(8'h73, 1'b0, 1'b1, '{CO | MI, RO | II | CE, Z, Z, Z});
    run_instr(8'h73, 1'b1, 1'b0, '{CO | MI, RO | II | CE, IO | J, Z, Z});
    run_instr(8'h85, 1'b1, 1'b0, '{CO | MI, RO | II | CE, Z, Z, Z});
    run_instr(8'h85, 1'b0, 1'b1, '{CO | MI, RO | II | CE, IO | J, Z, Z});
    run_instr(8'h1A, 1'b0, 1'b0, '{CO | MI, RO | II | CE, IO | MI, RO | AI, Z});
    run_instr(8'h2C, 1'b0, 1'b0, '{CO | MI, RO | II | CE, IO | MI, RO | BI, EO | AI | FI});
    run_instr(8'h4D, 1'b0, 1'b0, '{CO | MI, RO | II | CE, IO | MI, AO | RI, Z});
    run_instr(8'h57, 1'b0, 1'b0, '{CO | MI, RO | II | CE, IO | AI, Z, Z});
    run_instr(8'h63, 1'b0, 1'b0, '{CO | MI, RO | II | CE, IO | J, Z, Z});
    run_instr(8'hE0, 1'b0, 1'b0, '{CO | MI, RO | II | CE, AO | OI, Z, Z});
    run_instr(8'hB7, 1'b1, 1'b1, '{CO | MI, RO | II | CE, Z, Z, Z});
    chk("undef_halted", {15'b0, halted}, 16'h0000);

    do_halt(1'b0);
    do_halt(1'b1);

    // Program mode entered at T3 of an ADD, held for four edges.
    edge_t();
    ir = 8'h2E;
    sample();
    edge_t();
    sample();
    edge_t();
    sample();
    chk("prog_pre_t3", dut_word, RO | BI);
    #1;
    prog = 1'b1;
    for (int k = 0; k < 3; k++) begin
      edge_t();
      sample();
      chk("prog_tstep", {13'b0, tstep}, 16'h0000);
      chk("prog_word", dut_word, Z);
    end
    edge_t();
    prog = 1'b0;
    sample();
    chk("prog_exit_tstep", {13'b0, tstep}, 16'h0000);
    chk("prog_exit_word", dut_word, CO | MI);

    // clr in the middle of an ADD.
    edge_t();
    ir = 8'h2A;
    sample();
    edge_t();
    sample();
    edge_t();
    sample();
    chk("midclr_t3", dut_word, RO | BI);
    #1;
    clr = 1'b1;
    #1;
    chk("midclr_forced", dut_word, Z);
    edge_t();
    clr = 1'b0;
    sample();
    chk("midclr_tstep", {13'b0, tstep}, 16'h0000);
    chk("midclr_word", dut_word, CO | MI);

    run_instr(8'h3F, 1'b0, 1'b0, '{CO | MI, RO | II | CE, IO | MI, RO | BI, EO | AI | SU | FI});

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kwan_control_unit.md
Name: kwan_control_unit

Overview:
- Microcode sequencer for the 8-bit kwanCPU computer.
- Decodes the instruction register value into the per-T-state control word that drives the A/B registers, ALU, flags, MAR, RAM, program counter and output register.
- Generates the same ai/ao/bi/eo/su/fi strobes that benches currently drive by hand.
- Sits beside the datapath; its outputs connect directly to the computer's control inputs.

Parameters:
- N, 8, data/instruction width; opcode is ir[N-1:N-4], operand is ir[N-5:0].
- STEPS, 5, T-states per instruction; legal 5..8; steps 5..STEPS-1 are idle (all-zero control word).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  synchronous, active-high reset.
- ir  in  N  instruction register contents.
- cf  in  1  carry flag from the flags register.
- zf  in  1  zero flag from the flags register.
- prog  in  1  programming mode; switches own the bus and sequencer idles.
- co, mi, ro, ri, ii, io, ce, j  out  1 each  PC out, MAR in, RAM out, RAM in, IR in, IR operand out, PC count enable, PC jump/load.
- ai, ao, bi, eo, su, fi, oi  out  1 each  A in, A out, B in, ALU out, ALU subtract, flags in, output register in.
- hlt  out  1  halt strobe, combinational; high during T2 of HLT.
- halted  out  1  registered halt state.
- tstep  out  3  current T-state.

Behaviour:
- Step register tstep: cleared by clr; otherwise increments each rising edge and wraps STEPS-1 -> 0.
- prog=1: tstep is loaded with 0 at each edge and all control outputs are forced to 0. Fetch begins at T0 on the first edge after prog falls.
- Control word: combinational from tstep, opcode, cf and zf. It is forced to all-zero when clr=1, prog=1 or halted=1.
- Fetch, common to all opcodes: T0 co,mi; T1 ro,ii,ce.
- 0x0 NOP: T2-T4 nothing.
- 0x1 LDA: T2 io,mi; T3 ro,ai.
- 0x2 ADD: T2 io,mi; T3 ro,bi; T4 eo,ai,fi.
- 0x3 SUB: T2 io,mi; T3 ro,bi; T4 eo,ai,su,fi. su is asserted only in T4.
- 0x4 STA: T2 io,mi; T3 ao,ri.
- 0x5 LDI: T2 io,ai.
- 0x6 JMP: T2 io,j.
- 0x7 JC: T2 io,j only if cf=1; otherwise T2 is empty.
- 0x8 JZ: T2 io,j only if zf=1; otherwise T2 is empty.
- 0xE OUT: T2 ao,oi.
- 0xF HLT: T2 hlt.
- 0x9-0xD: undefined; execute as NOP (fetch only). No other side effect.
- No early termination: every instruction takes exactly STEPS cycles.
- Halt: on the edge where tstep=2 and opcode=0xF, halted is set to 1 and tstep freezes at 2. It stays set until clr; prog does not clear it.
- Flags are sampled combinationally during T2 only; changes to cf/zf in other steps have no effect.
- ir is treated as stable from T2 onward. ir changing during T0/T1 (the fetch load) has no effect on those steps.
- clr mid-instruction: on the next edge tstep=0 and halted=0, regardless of state. During clr all outputs are 0.
- Simultaneous clr and prog: clr wins for halted; tstep=0 either way.
- Reset values: tstep=0, halted=0, all strobes 0.
- First cycle after clr falls (prog=0): co=mi=1.

Test Plan:
- Fetch after reset: clr=1 for 2 edges, then clr=0, ir=0x00 -> tstep 0,1,2,3,4,0; co,mi=1 at T0; ro,ii,ce=1 at T1; all zero T2-T4.
- SUB decode: ir=0x3F -> T2 io,mi; T3 ro,bi; T4 eo,ai,su,fi all 1. su=0 in every other step. Sequence wraps to T0 after 5 cycles.
- Conditional jump: ir=0x73 with cf=0 -> T2 all-zero. Repeat with cf=1 -> T2 io=j=1. Same pair for ir=0x85 with zf=0/1.
- Halt and recovery: ir=0xF0 -> hlt=1 during T2; halted=1 after the edge; tstep holds at 2 with outputs 0 for 10 cycles. Pulse clr 1 cycle -> halted=0, tstep=0, co=mi=1.
- Program mode mid-instruction: ir=0x2E at tstep=3, assert prog for 4 edges -> tstep=0, all outputs 0. Deassert prog -> next cycle is T0 with co,mi=1.
- Undefined opcode: ir=0xB7 -> only the fetch strobes across all 5 steps; halted stays 0.
